// File: rtl/compare_arbiter.sv
// compare_arbiter: two-requester scheduler for a single 4-bit nibble comparator.
// Each WIDTH-bit operand pair is compared MSB nibble first, one nibble per cycle.
// Optional feature macro: COMPARE_EARLY_EXIT_EN. When it is defined, the compare
// ends on the first nibble that differs instead of always walking all nibbles.
//
// Handshake: a requester holds reqN high, with aN/bN stable, until gntN pulses
// for one cycle; its operands were captured on the edge that raised gntN.
// Exactly one cycle later or more, doneN pulses for one cycle with
// equal/a_greater/a_less valid. Those result registers then hold until the
// next completion.
module compare_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             equal,
  output logic             a_greater,
  output logic             a_less,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;
  typedef enum logic [1:0] {C_EQ, C_GT, C_LT} casc_t;

  state_t           state, state_nxt;
  casc_t            casc, casc_nxt;
  logic             ptr;
  logic             win;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             capture, pick, finish;
  logic [3:0]       a_nib, b_nib;

  // Operands shift left each CMP cycle, so the live nibble is always on top.
  assign a_nib = a_q[WIDTH-1 -: 4];
  assign b_nib = b_q[WIDTH-1 -: 4];

  // Arbitration, cascade update and next-state decision.
  always_comb begin
    state_nxt = state;
    casc_nxt  = casc;
    capture   = 1'b0;
    pick      = 1'b0;
    finish    = 1'b0;
    if (casc == C_EQ) begin
      if (a_nib > b_nib)      casc_nxt = C_GT;
      else if (a_nib < b_nib) casc_nxt = C_LT;
    end
`ifdef COMPARE_EARLY_EXIT_EN
    finish = (idx == '0) || (casc_nxt != C_EQ);
`else
    finish = (idx == '0);
`endif
    // With both requests up the pointer decides; otherwise the lone requester wins.
    pick = (req0 && req1) ? ptr : req1;
    case (state)
      S_IDLE: begin
        capture = req0 || req1;
        if (capture) state_nxt = S_CMP;
      end
      S_CMP:   if (finish) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, nibble sequencing, result loading and pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 1'b0;
      win       <= 1'b0;
      idx       <= '0;
      casc      <= C_EQ;
      a_q       <= '0;
      b_q       <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      equal     <= 1'b0;
      a_greater <= 1'b0;
      a_less    <= 1'b0;
    end else begin
      gnt0 <= capture && !pick;
      gnt1 <= capture && pick;
      case (state)
        S_IDLE: begin
          if (capture) begin
            a_q  <= pick ? a1 : a0;
            b_q  <= pick ? b1 : b0;
            win  <= pick;
            idx  <= IW'(NIB - 1);
            casc <= C_EQ;
          end
        end
        S_CMP: begin
          a_q  <= a_q << 4;
          b_q  <= b_q << 4;
          casc <= casc_nxt;
          idx  <= idx - IW'(1);
          if (finish) begin
            equal     <= (casc_nxt == C_EQ);
            a_greater <= (casc_nxt == C_GT);
            a_less    <= (casc_nxt == C_LT);
          end
        end
        S_DONE: ptr <= ~win;
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done0     = (state == S_DONE) && !win;
  assign done1     = (state == S_DONE) && win;
  assign state_dbg = state;

endmodule
